// File: rtl/div32_seq_pkg.sv
// Shared divider definitions: op-code encoding, FSM state encoding and
// the datapath width used across the core.
package div32_seq_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_CALC   = 2'b01,
    S_FINISH = 2'b10
  } div_state_e;

  // Magnitude of a two's-complement value when the op is signed; raw otherwise.
  function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v, input logic en);
    return (en && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_sub_step.sv
// Combinational trial subtractor for one restoring-division step:
// diff = rem - divisor as a ripple-carry add of ~divisor with carry-in 1.
module div_sub_step #(
  parameter int W = 33
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] diff,
  output logic         nonneg
);

  logic [W-1:0] carry;

  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_fa
      assign diff[gi] = rem[gi] ^ ~divisor[gi] ^ carry[gi];
      if (gi < W - 1) begin : g_carry
        assign carry[gi+1] = (rem[gi] & ~divisor[gi]) | (carry[gi] & (rem[gi] ^ ~divisor[gi]));
      end
    end
  endgenerate

  assign nonneg = ~diff[W-1];

endmodule

// File: rtl/div32_seq.sv
// Sequential restoring divider for DIV/DIVU/REM/REMU: one quotient bit per
// clock, with single-cycle fast paths for divide-by-zero and signed overflow.
module div32_seq
  import div32_seq_pkg::*;
#(
  parameter int N = XLEN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int CW = $clog2(N);

  div_state_e    state_reg, state_next;
  logic          rem_sel_reg, rem_sel_next;
  logic [N-1:0]  dq_reg, dq_next;
  logic [N-1:0]  rem_reg, rem_next;
  logic [N-1:0]  dsr_reg, dsr_next;
  logic          neg_q_reg, neg_q_next;
  logic          neg_r_reg, neg_r_next;
  logic [CW-1:0] count_reg, count_next;
  logic [N-1:0]  result_reg, result_next;
  logic          done_reg, done_next;
  logic          busy_reg, busy_next;

  logic          signed_op;
  logic [N-1:0]  a_abs, b_abs;
  logic [N:0]    rem_shift, trial;
  logic          trial_ok;
  logic [N-1:0]  q_final, r_final;

  assign signed_op = ~op[0];
  assign a_abs     = abs_if(dividend, signed_op);
  assign b_abs     = abs_if(divisor, signed_op);

  // The stored remainder is always below the divisor, so N bits suffice;
  // only the shifted trial operand needs the extra top bit.
  assign rem_shift = {rem_reg, dq_reg[N-1]};
  assign q_final   = neg_q_reg ? -dq_reg : dq_reg;
  assign r_final   = neg_r_reg ? -rem_reg : rem_reg;

  div_sub_step #(.W(N + 1)) u_step (
    .rem     (rem_shift),
    .divisor ({1'b0, dsr_reg}),
    .diff    (trial),
    .nonneg  (trial_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      rem_sel_reg <= 1'b0;
      dq_reg      <= '0;
      rem_reg     <= '0;
      dsr_reg     <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      count_reg   <= '0;
      result_reg  <= '0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rem_sel_reg <= rem_sel_next;
      dq_reg      <= dq_next;
      rem_reg     <= rem_next;
      dsr_reg     <= dsr_next;
      neg_q_reg   <= neg_q_next;
      neg_r_reg   <= neg_r_next;
      count_reg   <= count_next;
      result_reg  <= result_next;
      done_reg    <= done_next;
      busy_reg    <= busy_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    rem_sel_next = rem_sel_reg;
    dq_next      = dq_reg;
    rem_next     = rem_reg;
    dsr_next     = dsr_reg;
    neg_q_next   = neg_q_reg;
    neg_r_next   = neg_r_reg;
    count_next   = count_reg;
    result_next  = result_reg;
    done_next    = 1'b0;
    busy_next    = busy_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          rem_sel_next = op[1];
          busy_next    = 1'b1;
          count_next   = CW'(N - 1);
          rem_next     = '0;
          dq_next      = a_abs;
          dsr_next     = b_abs;
          neg_q_next   = signed_op & (dividend[N-1] ^ divisor[N-1]);
          neg_r_next   = signed_op & dividend[N-1];
          state_next   = S_CALC;
          // Fast paths preload final q/r with signs already resolved.
          if (divisor == '0) begin
            dq_next    = '1;
            rem_next   = dividend;
            neg_q_next = 1'b0;
            neg_r_next = 1'b0;
            state_next = S_FINISH;
          end else if (signed_op && dividend == {1'b1, {(N-1){1'b0}}} && divisor == '1) begin
            dq_next    = {1'b1, {(N-1){1'b0}}};
            rem_next   = '0;
            neg_q_next = 1'b0;
            neg_r_next = 1'b0;
            state_next = S_FINISH;
          end
        end
      end
      S_CALC: begin
        rem_next = trial_ok ? trial[N-1:0] : rem_shift[N-1:0];
        dq_next  = {dq_reg[N-2:0], trial_ok};
        if (count_reg == '0) begin
          state_next = S_FINISH;
        end else begin
          count_next = count_reg - 1'b1;
        end
      end
      S_FINISH: begin
        result_next = rem_sel_reg ? r_final : q_final;
        done_next   = 1'b1;
        busy_next   = 1'b0;
        state_next  = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;

endmodule

// File: doc/div32_seq.md
Name: div32_seq

Overview:
- Multi-cycle 32-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions.
- It is the inverse companion of the core's 32-bit adder: it performs restoring division by repeated trial subtraction, one quotient bit per clock.
- It sits beside the ALU in the execute stage.
- The execute stage asserts start and stalls the pipeline until done.

Parameters:
- N, 32, operand/result width. Only 32 is verified.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; accepted only while busy=0
- op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU (funct3[1:0])
- dividend  input  N  rs1 value; sampled on the accepting edge only
- divisor  input  N  rs2 value; sampled on the accepting edge only
- busy  output  1  high from the accepting edge until the edge that raises done
- done  output  1  single-cycle pulse; result is valid while done=1 and holds afterward
- result  output  N  quotient (DIV/DIVU) or remainder (REM/REMU)

Behaviour:
- Reset, which takes priority over everything including an operation in progress:
  - state=IDLE, busy=0, done=0, result=0, all internal registers=0.
  - An aborted operation never produces done.
- Clock and reset are the only timing references; there are no combinational input-to-output paths.

State machine IDLE -> CALC -> FINISH -> IDLE.
- IDLE:
  - If start=1 at an edge (edge T0), latch op.
  - Latch |dividend| and |divisor|. Absolute value applies only for signed ops (00, 10); unsigned ops take operands raw.
  - Record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend), both signed ops only.
  - Clear the 33-bit partial remainder; set count=N-1; busy=1.
- Fast paths, decided at T0:
  - Divisor==0: go directly to FINISH with q=all-ones and r=dividend (raw, unmodified), for both signed and unsigned ops.
  - Signed op with dividend=0x80000000 and divisor=0xFFFFFFFF: go to FINISH with q=0x80000000 and r=0.
  - Fast-path done rises at edge T0+1.
- CALC, once per edge:
  - rem = {rem[N-1:0], dq[N-1]}; dq shifts left by 1.
  - Trial = rem - {0,divisor_abs}, computed as a 33-bit add of the inverted divisor with carry-in 1.
  - If trial is non-negative (bit 32 = 0): rem = trial and the shifted-in quotient bit = 1. Otherwise rem is unchanged and the bit = 0.
  - Exit to FINISH after the edge where count==0. CALC therefore lasts exactly 32 edges (T0+1 .. T0+32).
- FINISH, one edge:
  - Apply sign: q = neg_q ? -q : q; r = neg_r ? -r : r, modulo 2^32.
  - Select result by op[1]; register result; done=1; busy=0; state=IDLE.
  - Normal-path done is high in the cycle following edge T0+33, so latency is 33 clocks from the accepting edge.
- Behaviour around done:
  - done lasts exactly one cycle.
  - start is accepted in the same cycle that done=1, since state is then IDLE. This allows back-to-back operations with no bubble.
- start while busy=1 is ignored: no queueing, no effect on the current operation.
- op/dividend/divisor may change after T0 without affecting the operation.
- Signed results truncate toward zero; the remainder takes the sign of the dividend, per the RISC-V spec.

Decomposition:
- Shared package (core-wide):
  - Op-code constants DIV_OP_DIV=2'b00, DIV_OP_DIVU=2'b01, DIV_OP_REM=2'b10, DIV_OP_REMU=2'b11.
  - State encoding S_IDLE/S_CALC/S_FINISH.
  - XLEN=32.
- One natural sub-module:
  - div_sub_step, a combinational 33-bit trial subtractor.
  - Inputs: partial remainder and divisor. Outputs: difference and a non-negative flag.
  - Built on ripple carry with carry-in 1 and the divisor inverted.
- FSM, counter, and sign logic stay in div32_seq.

Test Plan:
- DIVU 100/7 at T0 -> busy=1 from T0, done pulse after edge T0+33 with result=14; same operands with REMU -> result=2.
- DIV -20/3 (0xFFFFFFEC, 3) -> 0xFFFFFFFA (-6); REM -> 0xFFFFFFFE (-2); REM 20/-3 -> 2.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF; REM 0x80000000/0 -> 0x80000000; both give done at T0+1.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; done at T0+1. DIVU with the same operands -> 0, normal 33-clock latency.
- Protocol:
  - start asserted again at T0+5 with different operands -> ignored; first result unaffected.
  - start in the done cycle -> accepted; second result 33 clocks later.
  - rst at T0+10 -> busy=0, result=0, no done pulse.
- Random: 10k random signed/unsigned pairs (including 0, 1, -1, 0x7FFFFFFF, 0x80000000) checked against a reference model.
